// File: rtl/seg_display_scheduler_if.sv
// Requester/display bundle for seg_display_scheduler.
//   req   : per-requester request, held high until acked
//   data  : four packed 8-bit values, byte i belongs to requester i
//   ack   : one-hot single-cycle grant pulse
//   src   : index of the source currently on the display
//   busy  : scheduler is converting or showing a value
//   Y     : active-low segments
//   en    : active-low one-cold digit anodes
// The master side drives requests; the slave side is the scheduler.
interface seg_display_scheduler_if;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [1:0]  src;
  logic        busy;
  logic [6:0]  Y;
  logic [3:0]  en;

  modport master (
    output req, data,
    input  ack, src, busy, Y, en
  );

  modport slave (
    input  req, data,
    output ack, src, busy, Y, en
  );
endinterface

// File: rtl/seg_display_scheduler.sv
// Shares a 4-digit multiplexed seven-segment display among 4 requesters.
// Round-robin arbitration with req/ack, the granted byte is converted to BCD by a
// sequential double-dabble (one bit per clock), then shown for DWELL full scan frames.
// Ports:
//   clk : system clock, posedge
//   rst : asynchronous active-low reset
//   bus : seg_display_scheduler_if.slave (req/data in; ack/src/busy/Y/en out)
module seg_display_scheduler #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DWELL       = 100
) (
  input logic                    clk,
  input logic                    rst,
  seg_display_scheduler_if.slave bus
);

  localparam int unsigned DwellEff = (DWELL == 0) ? 1 : DWELL;

  typedef enum logic [1:0] {StIdle, StConvert, StShow} state_e;

  state_e      state_q, state_d;
  logic [31:0] presc_q, presc_d;
  logic [3:0]  en_q, en_d;
  logic [6:0]  y_q, y_d;
  logic [3:0]  ack_q, ack_d;
  logic [1:0]  src_q, src_d;
  logic [1:0]  rr_q, rr_d;
  logic [7:0]  bin_q, bin_d;
  logic [8:0]  bcd_q, bcd_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] frm_cnt_q, frm_cnt_d;
  logic [3:0]  ones_q, ones_d;
  logic [3:0]  tens_q, tens_d;
  logic [1:0]  hund_q, hund_d;

  logic        tick;
  logic        frame_done;
  logic [3:0]  digit_sel;
  logic        grant_vld;
  logic [1:0]  grant_idx;
  logic [8:0]  bcd_adj;
  logic [9:0]  bcd_shift;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Prescaler, anode scan and registered segment select. Runs in every state.
  always_comb begin
    tick       = (presc_q == REFRESH_DIV - 1);
    presc_d    = tick ? '0 : presc_q + 32'd1;
    en_d       = tick ? {en_q[2:0], en_q[3]} : en_q;
    frame_done = tick && (en_q == 4'b0111);
    case (en_q)
      4'b1110: digit_sel = ones_q;
      4'b1101: digit_sel = tens_q;
      4'b1011: digit_sel = {2'b00, hund_q};
      default: digit_sel = 4'd0;  // thousands digit is always 0
    endcase
    y_d = seg7(digit_sel);
  end

  // Round-robin search starting one past the last granted source.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] cand;
      cand = rr_q + 2'(k);
      if (!grant_vld && bus.req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the next binary bit.
  // Before the final shift the value is < 128, so one hundreds bit is enough in bcd_q.
  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    bcd_shift = {bcd_adj, bin_q[7]};
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = 4'b0000;
    src_d     = src_q;
    rr_d      = rr_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    frm_cnt_d = frm_cnt_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    hund_d    = hund_q;
    case (state_q)
      StIdle: begin
        if (grant_vld) begin
          ack_d     = 4'b0001 << grant_idx;
          src_d     = grant_idx;
          rr_d      = grant_idx;
          bin_d     = bus.data[8*grant_idx +: 8];
          bcd_d     = '0;
          bit_cnt_d = '0;
          frm_cnt_d = '0;
          state_d   = StConvert;
        end
      end
      StConvert: begin
        bcd_d     = bcd_shift[8:0];
        bin_d     = {bin_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          // Digits update only here so a partial conversion is never displayed.
          ones_d  = bcd_shift[3:0];
          tens_d  = bcd_shift[7:4];
          hund_d  = bcd_shift[9:8];
          state_d = StShow;
        end
      end
      StShow: begin
        if (frame_done) begin
          if (frm_cnt_q + 32'd1 == DwellEff) begin
            frm_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            frm_cnt_d = frm_cnt_q + 32'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      en_q      <= 4'b1110;
      y_q       <= 7'b0000001;
      ack_q     <= '0;
      src_q     <= '0;
      rr_q      <= 2'd3;  // source 0 gets first priority
      bin_q     <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      frm_cnt_q <= '0;
      ones_q    <= '0;
      tens_q    <= '0;
      hund_q    <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      en_q      <= en_d;
      y_q       <= y_d;
      ack_q     <= ack_d;
      src_q     <= src_d;
      rr_q      <= rr_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      frm_cnt_q <= frm_cnt_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      hund_q    <= hund_d;
    end
  end

  assign bus.ack  = ack_q;
  assign bus.src  = src_q;
  assign bus.busy = (state_q != StIdle);
  assign bus.Y    = y_q;
  assign bus.en   = en_q;

endmodule
